// File: rtl/vdp_sprite_line_scanner_if.sv
// Bundle of the sprite line scanner's line-control, attribute RAM and
// hit-list read signals.
//
// Modports:
//   master - the scanner: drives the attribute RAM address, the hit-list
//            read data and the status flags; receives line control, sprite
//            attributes and the renderer's read index.
//   slave  - the environment (line timing, attribute RAM, renderer).
//
// Signals:
//   start_new_line        one-cycle pulse: swap banks and start a scan
//   render_y              target line, sampled with start_new_line
//   freeze                sampled with start_new_line; 1 = no swap, no scan
//   sprite_read_address   attribute RAM read address (registered)
//   sprite_y              sprite top Y, valid one cycle after the address
//   sprite_height_select  00=8, 01=16, 10=32, 11=64 lines
//   sprite_flip_y         vertical flip
//   sprite_width_select   passed through into the hit-list entry
//   hit_list_read_address renderer read index
//   hit_list_read_data    {T, w, offset[5:0], id} from the read bank
//   busy / finished       scan in progress / one-cycle end-of-scan pulse
//   overflow              more hits than list entries on the current scan
//   hit_count             committed count of the read bank
interface vdp_sprite_line_scanner_if #(
    parameter int SPRITES_TOTAL  = 32,
    parameter int HIT_LIST_DEPTH = 8,
    parameter int Y_BITS         = 9
);
    localparam int ID_BITS  = (SPRITES_TOTAL > 1) ? $clog2(SPRITES_TOTAL) : 1;
    localparam int IDX_BITS = $clog2(HIT_LIST_DEPTH + 1);

    logic                  start_new_line;
    logic [Y_BITS-1:0]     render_y;
    logic                  freeze;
    logic [ID_BITS-1:0]    sprite_read_address;
    logic [Y_BITS-1:0]     sprite_y;
    logic [1:0]            sprite_height_select;
    logic                  sprite_flip_y;
    logic                  sprite_width_select;
    logic [IDX_BITS-1:0]   hit_list_read_address;
    logic [ID_BITS+7:0]    hit_list_read_data;
    logic                  busy;
    logic                  finished;
    logic                  overflow;
    logic [IDX_BITS-1:0]   hit_count;

    modport master (
        input  start_new_line, render_y, freeze,
        input  sprite_y, sprite_height_select, sprite_flip_y, sprite_width_select,
        input  hit_list_read_address,
        output sprite_read_address, hit_list_read_data,
        output busy, finished, overflow, hit_count
    );

    modport slave (
        output start_new_line, render_y, freeze,
        output sprite_y, sprite_height_select, sprite_flip_y, sprite_width_select,
        output hit_list_read_address,
        input  sprite_read_address, hit_list_read_data,
        input  busy, finished, overflow, hit_count
    );
endinterface

// File: rtl/vdp_sprite_line_scanner.sv
// Sprite line scanner: per scanline, walks the sprite Y attribute table,
// tests every sprite against the target line and builds a double-buffered
// hit list that the renderer reads back on the following line.
//
// Ports:
//   clk    clock
//   reset  synchronous, active-high reset
//   bus    vdp_sprite_line_scanner_if.master (line control, attribute RAM
//          read port, hit-list read port, busy/finished/overflow/hit_count)
//   The interface instance must use the same parameter values as this module.
//
// Optional build macro VDP_SPRITE_SCAN_EARLY_EXIT_EN: when defined, the first
// hit found with the list already full ends the scan at once (in-flight data
// discarded, remaining sprites untested). When undefined, every scan covers
// all sprites with fixed timing.
module vdp_sprite_line_scanner #(
    parameter int SPRITES_TOTAL  = 32,
    parameter int HIT_LIST_DEPTH = 8,
    parameter int Y_BITS         = 9
) (
    input logic                       clk,
    input logic                       reset,
    vdp_sprite_line_scanner_if.master bus
);
    localparam int ID_BITS  = (SPRITES_TOTAL > 1) ? $clog2(SPRITES_TOTAL) : 1;
    localparam int IDX_BITS = $clog2(HIT_LIST_DEPTH + 1);
    localparam int AW       = (HIT_LIST_DEPTH > 1) ? $clog2(HIT_LIST_DEPTH) : 1;
    localparam int ENTRY_W  = 8 + ID_BITS;
    localparam int CW       = (Y_BITS > 7) ? Y_BITS : 7;

    localparam logic [ID_BITS-1:0]  LAST_ID    = ID_BITS'(SPRITES_TOTAL - 1);
    localparam logic [IDX_BITS-1:0] DEPTH      = IDX_BITS'(HIT_LIST_DEPTH);
    localparam logic [ENTRY_W-1:0]  TERMINATOR = {1'b1, {(ENTRY_W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, DRAIN = 2'd2} state_t;

    function automatic logic [CW-1:0] line_height(input logic [1:0] sel);
        return CW'(8) << sel;
    endfunction

    // Wraps modulo 2^Y_BITS, so a sprite straddling the top of the Y range
    // still hits lines at the bottom of it.
    function automatic logic [CW-1:0] line_delta(input logic [Y_BITS-1:0] line_y,
                                                 input logic [Y_BITS-1:0] top_y);
        logic [Y_BITS-1:0] d;
        d = line_y - top_y;
        return CW'(d);
    endfunction

    function automatic logic [5:0] line_offset(input logic [CW-1:0] h,
                                               input logic [CW-1:0] d,
                                               input logic          flip);
        logic [CW-1:0] o;
        o = flip ? (h - CW'(1) - d) : d;
        return o[5:0];
    endfunction

    state_t                state, state_next;
    logic                  rb;
    logic                  wb;
    logic [IDX_BITS-1:0]   cnt [2];
    logic [ID_BITS-1:0]    addr_p0;
    logic [Y_BITS-1:0]     ry_p0;
    logic                  vld_p1;
    logic [ID_BITS-1:0]    id_p1;
    logic                  busy_q, finished_q, overflow_q;
    logic [ENTRY_W-2:0]    mem [2][HIT_LIST_DEPTH];

    logic                  do_start;
    logic [CW-1:0]         h, d;
    logic                  hit, full, wr_en, ovf_set, early;
    logic [ENTRY_W-2:0]    wr_data;
    logic [ENTRY_W-1:0]    rd_data;

    assign wb       = ~rb;
    assign do_start = bus.start_new_line && !bus.freeze;

    always_comb begin
        h       = line_height(bus.sprite_height_select);
        d       = line_delta(ry_p0, bus.sprite_y);
        hit     = vld_p1 && (d < h);
        full    = (cnt[wb] == DEPTH);
        wr_en   = hit && !full;
        ovf_set = hit && full;
        wr_data = {bus.sprite_width_select,
                   line_offset(h, d, bus.sprite_flip_y), id_p1};
`ifdef VDP_SPRITE_SCAN_EARLY_EXIT_EN
        early   = ovf_set && (state == SCAN);
`else
        early   = 1'b0;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // A start while busy abandons the current scan and restarts from id 0.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (do_start) state_next = SCAN;
            SCAN: begin
                if (do_start)                state_next = SCAN;
                else if (early)              state_next = DRAIN;
                else if (addr_p0 == LAST_ID) state_next = DRAIN;
            end
            DRAIN: state_next = do_start ? SCAN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Stage p0 -> p1: address issued, RAM data arrives on the next cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            rb         <= 1'b0;
            cnt[0]     <= '0;
            cnt[1]     <= '0;
            addr_p0    <= '0;
            vld_p1     <= 1'b0;
            busy_q     <= 1'b0;
            finished_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            finished_q <= 1'b0;
            vld_p1     <= (state == SCAN) && !do_start && !early;
            // A hit evaluated on the abort edge still lands in the bank
            // being handed to the renderer.
            if (wr_en)   cnt[wb]    <= cnt[wb] + IDX_BITS'(1);
            if (ovf_set) overflow_q <= 1'b1;
            if (do_start) begin
                rb         <= wb;
                cnt[rb]    <= '0;
                overflow_q <= 1'b0;
                addr_p0    <= '0;
                busy_q     <= 1'b1;
            end else if (state == SCAN && !early && addr_p0 != LAST_ID) begin
                addr_p0 <= addr_p0 + ID_BITS'(1);
            end else if (state == DRAIN) begin
                busy_q     <= 1'b0;
                finished_q <= 1'b1;
            end
        end
    end

    // Stage p1 -> list: evaluate the returned attribute and commit the entry
    always_ff @(posedge clk) begin
        id_p1 <= addr_p0;
        if (do_start) ry_p0 <= bus.render_y;
        if (wr_en)    mem[wb][cnt[wb][AW-1:0]] <= wr_data;
    end

    // Terminator is implicit: anything at or past the committed count reads as T=1.
    always_comb begin
        rd_data = TERMINATOR;
        if (bus.hit_list_read_address < cnt[rb])
            rd_data = {1'b0, mem[rb][bus.hit_list_read_address[AW-1:0]]};
    end

    assign bus.sprite_read_address = addr_p0;
    assign bus.hit_list_read_data  = rd_data;
    assign bus.busy                = busy_q;
    assign bus.finished            = finished_q;
    assign bus.overflow            = overflow_q;
    assign bus.hit_count           = cnt[rb];
endmodule

// File: tb/tb_vdp_sprite_line_scanner.sv
// Directed bench for vdp_sprite_line_scanner: a table of single-sprite hit
// cases plus hand-written sequences for overflow, abort, freeze and reset.
module tb_vdp_sprite_line_scanner;
    localparam int ST = 32;
    localparam int HD = 8;
    localparam int YB = 9;
    localparam logic [12:0] TERM = 13'h1000;
    localparam logic [8:0]  FAR_Y = 9'd400;

    logic clk;
    logic reset;

    vdp_sprite_line_scanner_if #(.SPRITES_TOTAL(ST), .HIT_LIST_DEPTH(HD), .Y_BITS(YB)) bus();

    vdp_sprite_line_scanner #(.SPRITES_TOTAL(ST), .HIT_LIST_DEPTH(HD), .Y_BITS(YB)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [8:0] ytab   [ST];
    logic [1:0] seltab [ST];
    logic       fliptab[ST];
    logic       wtab   [ST];

    // Attribute RAM with one cycle of read latency
    always @(posedge clk) begin
        bus.sprite_y             <= ytab[bus.sprite_read_address];
        bus.sprite_height_select <= seltab[bus.sprite_read_address];
        bus.sprite_flip_y        <= fliptab[bus.sprite_read_address];
        bus.sprite_width_select  <= wtab[bus.sprite_read_address];
    end

    int nvec  = 0;
    int nfail = 0;

    typedef struct {
        int         id;
        logic [8:0] y;
        logic [1:0] sel;
        logic       flip;
        logic       w;
        logic [8:0] ry;
        logic       hit;
        logic [5:0] off;
    } vec_t;

    localparam int NV = 10;
    vec_t vecs [NV];

    function automatic logic [12:0] ent(input logic w, input logic [5:0] off, input logic [4:0] id);
        return {1'b0, w, off, id};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_entry(input string name, input int idx, input logic [12:0] exp);
        bus.hit_list_read_address = 4'(idx);
        #1;
        check($sformatf("%s[%0d]", name, idx), 32'(bus.hit_list_read_data), 32'(exp));
    endtask

    task automatic clear_table();
        for (int i = 0; i < ST; i++) begin
            ytab[i]    = FAR_Y;
            seltab[i]  = 2'b00;
            fliptab[i] = 1'b0;
            wtab[i]    = 1'b0;
        end
    endtask

    task automatic pulse_start(input logic [8:0] ry, input logic frz);
        @(negedge clk);
        bus.start_new_line = 1'b1;
        bus.render_y       = ry;
        bus.freeze         = frz;
        @(negedge clk);
        bus.start_new_line = 1'b0;
        bus.freeze         = 1'b0;
    endtask

    task automatic wait_finished(input string name, output int cyc);
        cyc = 0;
        while (bus.finished !== 1'b1 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check({name, "_finished"}, 32'(bus.finished), 32'd1);
    endtask

    initial begin
        int  cyc;
        int  fin_seen;

        vecs[0] = '{3,  9'd100, 2'b01, 1'b0, 1'b0, 9'd107, 1'b1, 6'd7};
        vecs[1] = '{3,  9'd100, 2'b01, 1'b1, 1'b0, 9'd107, 1'b1, 6'd8};
        vecs[2] = '{5,  9'd508, 2'b01, 1'b0, 1'b1, 9'd2,   1'b1, 6'd6};
        vecs[3] = '{3,  9'd100, 2'b00, 1'b0, 1'b0, 9'd108, 1'b0, 6'd0};
        vecs[4] = '{3,  9'd100, 2'b00, 1'b1, 1'b0, 9'd107, 1'b1, 6'd0};
        vecs[5] = '{7,  9'd10,  2'b11, 1'b0, 1'b1, 9'd73,  1'b1, 6'd63};
        vecs[6] = '{7,  9'd10,  2'b10, 1'b0, 1'b0, 9'd42,  1'b0, 6'd0};
        vecs[7] = '{7,  9'd10,  2'b10, 1'b1, 1'b0, 9'd41,  1'b1, 6'd0};
        vecs[8] = '{7,  9'd10,  2'b11, 1'b0, 1'b0, 9'd9,   1'b0, 6'd0};
        vecs[9] = '{31, 9'd0,   2'b01, 1'b0, 1'b1, 9'd15,  1'b1, 6'd15};

        reset                     = 1'b1;
        bus.start_new_line        = 1'b0;
        bus.render_y              = '0;
        bus.freeze                = 1'b0;
        bus.hit_list_read_address = '0;
        clear_table();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Reset state
        for (int i = 0; i <= HD; i++) check_entry("reset_entry", i, TERM);
        check("reset_hit_count", 32'(bus.hit_count), 32'd0);
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_finished", 32'(bus.finished), 32'd0);
        check("reset_overflow", 32'(bus.overflow), 32'd0);
        check("reset_addr", 32'(bus.sprite_read_address), 32'd0);

        // Single-sprite hit table
        for (int v = 0; v < NV; v++) begin
            clear_table();
            ytab[vecs[v].id]    = vecs[v].y;
            seltab[vecs[v].id]  = vecs[v].sel;
            fliptab[vecs[v].id] = vecs[v].flip;
            wtab[vecs[v].id]    = vecs[v].w;
            pulse_start(vecs[v].ry, 1'b0);
            check($sformatf("v%0d_busy", v), 32'(bus.busy), 32'd1);
            wait_finished($sformatf("v%0d", v), cyc);
            if (v == 0) check("scan_length", 32'(cyc), 32'(ST + 1));
            check($sformatf("v%0d_busy_end", v), 32'(bus.busy), 32'd0);
            pulse_start(vecs[v].ry, 1'b0);
            check_entry($sformatf("v%0d_idx", v), 0,
                        vecs[v].hit ? ent(vecs[v].w, vecs[v].off, 5'(vecs[v].id)) : TERM);
            check_entry($sformatf("v%0d_idx", v), 1, TERM);
            check($sformatf("v%0d_hit_count", v), 32'(bus.hit_count), 32'(vecs[v].hit));
            wait_finished($sformatf("v%0d_b", v), cyc);
        end

        // Ten sprites on line 50 with an 8-deep list
        clear_table();
        for (int i = 0; i < 10; i++) ytab[i] = 9'd45;
        pulse_start(9'd50, 1'b0);
        wait_finished("ovf", cyc);
`ifdef VDP_SPRITE_SCAN_EARLY_EXIT_EN
        check("ovf_scan_length", 32'(cyc), 32'd11);
`else
        check("ovf_scan_length", 32'(cyc), 32'(ST + 1));
`endif
        check("ovf_flag", 32'(bus.overflow), 32'd1);
        pulse_start(9'd50, 1'b0);
        check("ovf_cleared_on_start", 32'(bus.overflow), 32'd0);
        check("ovf_hit_count", 32'(bus.hit_count), 32'd8);
        for (int i = 0; i < HD; i++) check_entry("ovf_entry", i, ent(1'b0, 6'd5, 5'(i)));
        check_entry("ovf_entry", HD, TERM);
        check_entry("ovf_entry", 15, TERM);
        wait_finished("ovf_b", cyc);

        // Abort: second start lands on edge 10 of the scan
        clear_table();
        ytab[2] = 9'd45;
        ytab[5] = 9'd45;
        ytab[8] = 9'd45;
        ytab[9] = 9'd45;
        pulse_start(9'd50, 1'b0);
        repeat (8) @(negedge clk);
        pulse_start(9'd50, 1'b0);
        check("abort_hit_count", 32'(bus.hit_count), 32'd3);
        check_entry("abort_entry", 0, ent(1'b0, 6'd5, 5'd2));
        check_entry("abort_entry", 1, ent(1'b0, 6'd5, 5'd5));
        check_entry("abort_entry", 2, ent(1'b0, 6'd5, 5'd8));
        check_entry("abort_entry", 3, TERM);
        wait_finished("abort_restart", cyc);
        check("abort_restart_length", 32'(cyc), 32'(ST + 1));
        pulse_start(9'd50, 1'b0);
        check("restart_hit_count", 32'(bus.hit_count), 32'd4);
        check_entry("restart_entry", 3, ent(1'b0, 6'd5, 5'd9));
        wait_finished("restart_b", cyc);

        // Freeze: no swap, no scan
        pulse_start(9'd50, 1'b1);
        check("freeze_busy", 32'(bus.busy), 32'd0);
        check("freeze_hit_count", 32'(bus.hit_count), 32'd4);
        check_entry("freeze_entry", 0, ent(1'b0, 6'd5, 5'd2));
        check_entry("freeze_entry", 3, ent(1'b0, 6'd5, 5'd9));
        check("freeze_addr", 32'(bus.sprite_read_address), 32'(ST - 1));
        @(negedge clk);
        check("freeze_busy_later", 32'(bus.busy), 32'd0);

        // Reset in the middle of a scan
        pulse_start(9'd50, 1'b0);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midreset_busy", 32'(bus.busy), 32'd0);
        check("midreset_hit_count", 32'(bus.hit_count), 32'd0);
        check("midreset_addr", 32'(bus.sprite_read_address), 32'd0);
        check_entry("midreset_entry", 0, TERM);
        fin_seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.finished === 1'b1 || bus.busy === 1'b1) fin_seen++;
        end
        check("midreset_quiet", 32'(fin_seen), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule
